// File: rtl/sat_arith_pkg.sv
// Shared definitions for the saturating arithmetic units: widths, clamp
// constants, FSM states and the overflow clamp rule for subtraction.
package sat_arith_pkg;

    localparam int DATA_W = 16;
    localparam int NIB_W  = 4;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] diff;
        logic              ovfl;
    } sat_res_t;

    // Overflow of a - b is visible only when the operand signs differ and the
    // raw sign disagrees with the minuend; the carry-out plays no part.
    function automatic sat_res_t sat_sub_clamp(input logic a_sign,
                                               input logic b_sign,
                                               input logic [DATA_W-1:0] raw);
        sat_res_t r;
        r.diff = raw;
        r.ovfl = 1'b0;
        if (!a_sign && b_sign && raw[DATA_W-1]) begin
            r.diff = SAT_MAX;
            r.ovfl = 1'b1;
        end else if (a_sign && !b_sign && !raw[DATA_W-1]) begin
            r.diff = SAT_MIN;
            r.ovfl = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit carry-lookahead adder slice, shared by every nibble
// of the serial subtractor.
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries are flattened from generate/propagate rather than rippled.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/sat_sub_serial.sv
// Nibble-serial 16-bit signed saturating subtractor: A - B computed as
// A + ~B + 1 through one 4-bit slice, result clamped on overflow.
module sat_sub_serial
    import sat_arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Diff,
    output logic              ovfl,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] raw_nx;
    logic              carry;

    logic [NIB_W-1:0]  nib_a;
    logic [NIB_W-1:0]  nib_b;
    logic [NIB_W-1:0]  nib_sum;
    logic              nib_cout;
    sat_res_t          sat;

    assign nib_a = op_a[{cnt, 2'b00} +: NIB_W];
    assign nib_b = op_b[{cnt, 2'b00} +: NIB_W];

    nibble_adder u_nib (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Raw result with the current nibble merged in, so the last nibble and
    // the clamp land on the same edge that enters DONE.
    always_comb begin
        raw_nx = raw;
        raw_nx[{cnt, 2'b00} +: NIB_W] = nib_sum;
    end

    assign sat = sat_sub_clamp(op_a[DATA_W-1], ~op_b[DATA_W-1], raw_nx);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == 2'd3) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            raw   <= '0;
            carry <= 1'b0;
            Diff  <= '0;
            ovfl  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= A;
                        op_b  <= ~B;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    raw   <= raw_nx;
                    carry <= nib_cout;
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        Diff <= sat.diff;
                        ovfl <= sat.ovfl;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sat_sub_serial.sv
// Scoreboard bench for sat_sub_serial: stimulus pushes expected results,
// a negedge monitor pops and compares value and arrival cycle on done.
module tb_sat_sub_serial;

    typedef struct {
        logic [15:0] diff;
        logic        ov;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Diff;
    logic        ovfl;
    logic        busy;
    logic        done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   next_free = 0;
    exp_t q[$];
    exp_t mon_e;

    logic [15:0] corners [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    logic [15:0] dir_a   [8] = '{16'h0005, 16'h7FFF, 16'h0000, 16'h8000, 16'h8001, 16'h1234, 16'h0F0F, 16'hFFFF};
    logic [15:0] dir_b   [8] = '{16'h0003, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'h1234, 16'h00F1, 16'h7FFF};

    sat_sub_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Diff  (Diff),
        .ovfl  (ovfl),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: exact integer difference, clamped to the signed 16-bit range.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   d;
        d = int'($signed(a)) - int'($signed(b));
        e.cyc = 0;
        if (d > 32767) begin
            e.diff = 16'h7FFF; e.ov = 1'b1;
        end else if (d < -32768) begin
            e.diff = 16'h8000; e.ov = 1'b1;
        end else begin
            e.diff = d[15:0];  e.ov = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [15:0] rnd16();
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        while (cyc + 1 < next_free) @(negedge clk);
        A = a; B = b; start = 1'b1;
        e = model(a, b);
        e.cyc = cyc + 5;
        q.push_back(e);
        next_free = cyc + 7;
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("diff", {16'h0, Diff}, {16'h0, mon_e.diff});
                chk("ovfl", {31'h0, ovfl}, {31'h0, mon_e.ov});
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_done: got no done expected done at cycle %0d (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("rst_diff", {16'h0, Diff}, 32'h0);
        chk("rst_ovfl", {31'h0, ovfl}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        rst = 1'b0;
        next_free = cyc + 1;

        // First op also checks the busy window.
        issue(dir_a[0], dir_b[0]);
        for (int i = 0; i < 5; i++) begin
            chk("busy_hi", {31'h0, busy}, 32'h1);
            @(negedge clk);
        end
        chk("busy_lo", {31'h0, busy}, 32'h0);

        for (int i = 1; i < 8; i++) issue(dir_a[i], dir_b[i]);
        for (int i = 0; i < 40; i++) issue(rnd16(), rnd16());

        // start held high with operands changing every cycle.
        while (cyc + 1 < next_free) @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            A = rnd16(); B = rnd16();
            if (cyc + 1 >= next_free) begin
                exp_t e;
                e = model(A, B);
                e.cyc = cyc + 5;
                q.push_back(e);
                next_free = cyc + 7;
            end
            @(negedge clk);
        end
        start = 1'b0;

        // Abort mid-RUN; start with rst must also be ignored.
        issue(16'h1234, 16'h0042);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        chk("abort_diff", {16'h0, Diff}, 32'h0);
        chk("abort_ovfl", {31'h0, ovfl}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        rst = 1'b0; start = 1'b0;
        next_free = cyc + 1;
        issue(16'h0001, 16'h0002);

        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);
        chk("final_diff", {16'h0, Diff}, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
